alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
// - Downstream stage of the 4-bit logic ALU (AND/OR/NAND/NOR, 2-bit sel).
// - Captures each ALU result together with the sel code that produced it.
// - Buffers results in a small synchronous FIFO; consumer drains via valid/ready.
// - Decouples the ALU issue rate from a slower or stalling consumer.
// PARAMETERS
// - DATA_W  4  ALU result width; matches ALU_out.
// - SEL_W   2  op-select width stored with each entry.
// - DEPTH   4  number of entries; power of 2, >= 2.
// - ADDR_W  2  log2(DEPTH); pointer width.
// PORTS
// - clk        in   1           single clock, rising edge.
// - rst        in   1           asynchronous, active-high reset.
// - in_valid   in   1           ALU result present this cycle.
// - in_ready   out  1           FIFO accepts a push; equals !full.
// - in_data    in   DATA_W      ALU_out value.
// - in_sel     in   SEL_W       sel applied to the ALU for in_data.
// - out_valid  out  1           head entry is valid; equals !empty.
// - out_ready  in   1           consumer takes the head entry.
// - out_data   out  DATA_W      head entry result.
// - out_sel    out  SEL_W       head entry sel code.
// - count      out  ADDR_W+1    current occupancy, 0..DEPTH.
// - ovf_err    out  1           sticky: push attempted while full.
// BEHAVIOUR
// - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, ovf_err=0.
//   out_valid=0, in_ready=1, out_data=0, out_sel=0. Storage contents are don't-care.
// - push = in_valid & in_ready; pop = out_valid & out_ready.
//   Both are evaluated on the same clk edge.
// - Storage is a register array. out_data/out_sel = mem[rd_ptr], combinational read of a registered array.
// - Latency: an entry pushed at edge N is visible at out_* with out_valid=1 after edge N.
//   There is no same-cycle bypass; an empty FIFO never forwards in_data.
// - in_ready and out_valid derive only from count. There is no combinational path from out_ready to in_ready.
// - Pointers wrap modulo DEPTH: DEPTH-1 -> 0.
// - count: +1 on push only, -1 on pop only, unchanged on push&pop.
// - Full (count==DEPTH):
//   - in_ready=0.
//   - A pop in this cycle does not enable a same-cycle push.
//   - in_valid=1 while full sets ovf_err=1. Data is dropped; pointers do not move.
// - Empty (count==0):
//   - out_valid=0; out_ready is ignored; no pointer or count change.
//   - out_data/out_sel hold mem[rd_ptr] (stale, don't-care).
// - Simultaneous push and pop with 0<count<DEPTH: both occur. The head advances and the tail is written.
// - ovf_err clears only on rst.
// - Reset mid-operation: all entries are discarded immediately. Outputs return to reset values asynchronously.
// - in_data/in_sel are sampled only on push.
// - out_data/out_sel are stable while out_valid=1 and out_ready=0.
// CONFIGURATION
// - Macro ALU_RESULT_FIFO_ZERO_FLAG_EN.
// - Defined:
//   - Each entry stores an extra bit z = (in_data == 0), computed at push.
//   - Extra output port out_zero (1 bit) = z of the head entry.
//   - out_zero resets to 0.
//   - It follows the same stability rule as out_data.
// - Undefined: no z storage and no out_zero port. All other behaviour is identical.
// TESTING
// - Reset then idle: after rst deasserts, the bench requires:
//   count=0, out_valid=0, in_ready=1, ovf_err=0.
// - Single push: in_data=4'hA, in_sel=2'b01 for one cycle, out_ready=0.
//   Next cycle requires: out_valid=1, out_data=4'hA, out_sel=01, count=1.
// - Fill and overflow:
//   - Push 1,2,3,4 with out_ready=0. Requires count=4 and in_ready=0.
//   - Then push 4'hF. Requires ovf_err=1, count=4, and the 4'hF entry dropped.
// - Drain order: from full, hold out_ready=1 for 4 cycles.
//   Requires out_data sequence 1,2,3,4; then out_valid=0, count=0.
// - Simultaneous push and pop at count=2, repeated 6 cycles with data 5..A:
//   - count stays 2.
//   - Output order is contiguous, covering the pointer wrap.
// - Reset mid-stream: rst pulse at count=3. Requires count=0 and out_valid=0 asynchronously.
//   ZERO_FLAG_EN: push 4'h0 -> out_zero=1; push 4'h3 -> out_zero=0.

Source files
------------

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and the consumer.
// The out_zero signal exists only when ALU_RESULT_FIFO_ZERO_FLAG_EN is defined.
interface alu_result_fifo_if #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
    logic [ADDR_W:0]   count;
    logic              ovf_err;
`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
    logic              out_zero;
`endif

    // Environment side: drives pushes and consumer ready, observes everything else.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel, count, ovf_err
`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
        , input out_zero
`endif
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel, count, ovf_err
`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
        , output out_zero
`endif
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small synchronous FIFO buffering ALU results with their sel code.
// Optional feature macro: ALU_RESULT_FIFO_ZERO_FLAG_EN adds a per-entry zero flag
// and the out_zero port. Reset is asynchronous and active-high.
module alu_result_fifo #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_result_fifo_if.slave bus
);

`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
    localparam int ENTRY_W = DATA_W + SEL_W + 1;
`else
    localparam int ENTRY_W = DATA_W + SEL_W;
`endif

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  rd_ptr_reg;
    logic [ADDR_W:0]    count_reg;
    logic               ovf_err_reg;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Flags come from the occupancy register only, so out_ready never reaches in_ready.
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
    assign wr_entry = {(bus.in_data == '0), bus.in_sel, bus.in_data};
`else
    assign wr_entry = {bus.in_sel, bus.in_data};
`endif

    // Storage: the tail entry is written on push. Entries are cleared on reset so
    // the head outputs read as zero after reset even though the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (bus.in_valid && full) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    // Head entry is a combinational read of the registered array (no bypass).
    assign rd_entry      = mem_reg[rd_ptr_reg];
    assign bus.out_data  = rd_entry[DATA_W-1:0];
    assign bus.out_sel   = rd_entry[DATA_W +: SEL_W];
`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
    assign bus.out_zero  = rd_entry[ENTRY_W-1];
`endif
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.count     = count_reg;
    assign bus.ovf_err   = ovf_err_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with a queue scoreboard for popped entries.
module tb_alu_result_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   mcount  = 0;
    logic [5:0] sbq [$];

    always #5 clk = ~clk;

    alu_result_fifo_if #(.DATA_W(4), .SEL_W(2), .ADDR_W(2)) bus ();

    alu_result_fifo #(.DATA_W(4), .SEL_W(2), .DEPTH(4), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model push/pop decision, scoreboard compare on pop, then advance.
    task automatic cycle();
        bit push;
        bit pop;
        logic [5:0] e;
        push = bus.in_valid && (mcount < 4);
        pop  = bus.out_ready && (mcount > 0);
        if (pop) begin
            e = sbq.pop_front();
            chk("pop_data", 8'(bus.out_data), 8'(e[3:0]));
            chk("pop_sel", 8'(bus.out_sel), 8'(e[5:4]));
`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
            chk("pop_zero", 8'(bus.out_zero), 8'(e[3:0] == 4'h0));
`endif
        end
        @(posedge clk);
        #1;
        if (push) sbq.push_back({bus.in_sel, bus.in_data});
        mcount = mcount + int'(push) - int'(pop);
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = r;
    endtask

    initial begin
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_count", 8'(bus.count), 8'd0);
        chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
        chk("rst_ovf", 8'(bus.ovf_err), 8'd0);
        chk("rst_out_data", 8'(bus.out_data), 8'd0);
        chk("rst_out_sel", 8'(bus.out_sel), 8'd0);

        // Empty FIFO never forwards in_data combinationally
        drive(1'b1, 4'hA, 2'b01, 1'b0);
        #1;
        chk("no_bypass", 8'(bus.out_valid), 8'd0);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        chk("single_valid", 8'(bus.out_valid), 8'd1);
        chk("single_data", 8'(bus.out_data), 8'hA);
        chk("single_sel", 8'(bus.out_sel), 8'd1);
        chk("single_count", 8'(bus.count), 8'd1);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cycle();
        chk("single_drained", 8'(bus.count), 8'd0);

        // Fill 1..4 with distinct sel codes
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 2'(i), 1'b0);
            cycle();
        end
        chk("full_count", 8'(bus.count), 8'd4);
        chk("full_in_ready", 8'(bus.in_ready), 8'd0);
        chk("full_ovf_pre", 8'(bus.ovf_err), 8'd0);

        // Overflow push of 4'hF is dropped; head remains stable
        drive(1'b1, 4'hF, 2'b11, 1'b0);
        cycle();
        chk("ovf_set", 8'(bus.ovf_err), 8'd1);
        chk("ovf_count", 8'(bus.count), 8'd4);
        chk("ovf_head_stable", 8'(bus.out_data), 8'h1);

        // Drain from full; first cycle also offers a push that must not be taken
        drive(1'b1, 4'hE, 2'b10, 1'b1);
        cycle();
        chk("pop_full_no_push", 8'(bus.count), 8'd3);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        repeat (3) cycle();
        chk("drain_valid", 8'(bus.out_valid), 8'd0);
        chk("drain_count", 8'(bus.count), 8'd0);
        chk("ovf_sticky", 8'(bus.ovf_err), 8'd1);

        // Pop request on empty is ignored
        cycle();
        chk("empty_pop_count", 8'(bus.count), 8'd0);

        // Reach count=2 then simultaneous push/pop with 5..A across the wrap
        drive(1'b1, 4'hC, 2'b00, 1'b0);
        cycle();
        drive(1'b1, 4'hD, 2'b01, 1'b0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(5 + i), 2'(i), 1'b1);
            cycle();
            chk("pp_count", 8'(bus.count), 8'd2);
        end

        // Build to count=3, then an asynchronous reset pulse between edges
        drive(1'b1, 4'h7, 2'b10, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        chk("pre_rst_count", 8'(bus.count), 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 8'(bus.count), 8'd0);
        chk("async_rst_valid", 8'(bus.out_valid), 8'd0);
        chk("async_rst_ready", 8'(bus.in_ready), 8'd1);
        chk("async_rst_ovf", 8'(bus.ovf_err), 8'd0);
        chk("async_rst_data", 8'(bus.out_data), 8'd0);
        sbq.delete();
        mcount = 0;
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef ALU_RESULT_FIFO_ZERO_FLAG_EN
        chk("zero_rst", 8'(bus.out_zero), 8'd0);
        drive(1'b1, 4'h0, 2'b11, 1'b0);
        cycle();
        chk("zero_set", 8'(bus.out_zero), 8'd1);
        drive(1'b1, 4'h3, 2'b10, 1'b1);
        cycle();
        chk("zero_clear", 8'(bus.out_zero), 8'd0);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        cycle();
`endif

        // Post-reset sanity push
        drive(1'b1, 4'h9, 2'b10, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        chk("post_rst_data", 8'(bus.out_data), 8'h9);
        chk("post_rst_count", 8'(bus.count), 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
